// File: rtl/alu_result_if.sv
// alu_result_if: capture/handshake bundle between the UC, logic unit, result stage and write-back.
interface alu_result_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] ALUOut;
  logic              OVERFLOW;
  logic              ZERO;
  logic              Update_UC;
  logic              capture;
  logic              ovf_check;
  logic              br_eq;
  logic              br_ne;
  logic              br_cmp;
  logic [DATA_W-1:0] PC_in;
  logic              wb_ready;
  logic              exc_ack;
  logic [DATA_W-1:0] ALUOut_q;
  logic              result_valid;
  logic              branch_taken;
  logic              exc_req;
  logic [DATA_W-1:0] EPC_q;
  logic              busy;
  logic [CNT_W-1:0]  exc_count;
  modport master (
    output ALUOut, OVERFLOW, ZERO, Update_UC, capture, ovf_check, br_eq, br_ne, br_cmp, PC_in, wb_ready, exc_ack,
    input  ALUOut_q, result_valid, branch_taken, exc_req, EPC_q, busy, exc_count
  );
  modport slave (
    input  ALUOut, OVERFLOW, ZERO, Update_UC, capture, ovf_check, br_eq, br_ne, br_cmp, PC_in, wb_ready, exc_ack,
    output ALUOut_q, result_valid, branch_taken, exc_req, EPC_q, busy, exc_count
  );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: registers logic-unit results, resolves branches, traps overflow with EPC.
// Optional ALU_RESULT_EXC_CNT_EN adds a saturating overflow-exception counter.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input logic         clk,
  input logic         reset,
  alu_result_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] EXC  = 2'd2;
  logic [1:0] state, state_nx;
  logic accept, trap, release_hold, br_term;
  logic [DATA_W-1:0] alu_q, epc_q;
  logic br_q;
  assign accept       = bus.capture & ((state == IDLE) | ((state == HOLD) & bus.wb_ready));
  assign trap         = accept & bus.ovf_check & bus.OVERFLOW;
  assign release_hold = (state == HOLD) & bus.wb_ready;
  assign br_term      = (bus.br_eq & bus.ZERO) | (bus.br_ne & ~bus.ZERO) | (bus.br_cmp & bus.Update_UC);
  always_comb begin
    state_nx = accept ? (trap ? EXC : HOLD) :
               (release_hold | ((state == EXC) & bus.exc_ack)) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      alu_q <= '0;
      epc_q <= '0;
      br_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && !trap) alu_q <= bus.ALUOut;
      if (trap) epc_q <= bus.PC_in;
      if (accept) br_q <= ~trap & br_term;
      else if (release_hold) br_q <= 1'b0;
    end
  end
  assign bus.ALUOut_q     = alu_q;
  assign bus.EPC_q        = epc_q;
  assign bus.branch_taken = br_q;
  assign bus.result_valid = (state == HOLD);
  assign bus.exc_req      = (state == EXC);
  assign bus.busy         = (state != IDLE);
`ifdef ALU_RESULT_EXC_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else if (trap && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign bus.exc_count = cnt_q;
`else
  assign bus.exc_count = '0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random checks of alu_result_stage against a transaction-level model.
module tb_alu_result_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_valid, m_exc, m_br;
  logic [31:0] m_alu, m_epc;
  int m_cnt;
  alu_result_if #(.DATA_W(32), .CNT_W(2)) bus ();
  alu_result_stage #(.DATA_W(32), .CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_cnt();
`ifdef ALU_RESULT_EXC_CNT_EN
    return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
`else
    return 2'd0;
`endif
  endfunction

  task automatic quiet();
    bus.ALUOut = '0; bus.OVERFLOW = 0; bus.ZERO = 0; bus.Update_UC = 0; bus.capture = 0;
    bus.ovf_check = 0; bus.br_eq = 0; bus.br_ne = 0; bus.br_cmp = 0; bus.PC_in = '0;
    bus.wb_ready = 0; bus.exc_ack = 0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_exc = 0; m_br = 0; m_alu = '0; m_epc = '0; m_cnt = 0;
  endtask

  // One clock: the model applies the transaction rules to the inputs seen at the edge.
  task automatic step();
    bit can, tr, drop, ack, br;
    logic [31:0] a, pc;
    can  = bus.capture && ((!m_valid && !m_exc) || (m_valid && bus.wb_ready));
    tr   = can && bus.ovf_check && bus.OVERFLOW;
    drop = m_valid && bus.wb_ready;
    ack  = m_exc && bus.exc_ack;
    br   = (bus.br_eq && bus.ZERO) || (bus.br_ne && !bus.ZERO) || (bus.br_cmp && bus.Update_UC);
    a = bus.ALUOut; pc = bus.PC_in;
    @(posedge clk); #1;
    if (tr) begin m_exc = 1; m_valid = 0; m_br = 0; m_epc = pc; m_cnt++; end
    else if (can) begin m_valid = 1; m_alu = a; m_br = br; end
    else if (drop) begin m_valid = 0; m_br = 0; end
    else if (ack) m_exc = 0;
  endtask

  task automatic capture_op(input logic [31:0] a, input bit ovc, input bit ovf, input logic [31:0] pc);
    bus.capture = 1; bus.ALUOut = a; bus.ovf_check = ovc; bus.OVERFLOW = ovf; bus.PC_in = pc;
    step();
    quiet();
  endtask

  task automatic test_reset();
    quiet(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.result_valid !== 1'b0 || bus.exc_req !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_flags: valid/exc/busy=%b%b%b want 000", bus.result_valid, bus.exc_req, bus.busy); end
    n_cmp++; if (bus.ALUOut_q !== 32'h0 || bus.EPC_q !== 32'h0) begin n_bad++; $display("FAIL reset_data: ALUOut_q=%h EPC_q=%h want 0", bus.ALUOut_q, bus.EPC_q); end
    n_cmp++; if (bus.branch_taken !== 1'b0 || bus.exc_count !== 2'd0) begin n_bad++; $display("FAIL reset_misc: br=%b cnt=%0d want 0", bus.branch_taken, bus.exc_count); end
    @(negedge clk); reset = 1;
    @(negedge clk);
  endtask

  task automatic test_result();
    capture_op(32'h2A, 0, 0, 32'h10);
    n_cmp++; if (bus.ALUOut_q !== 32'h2A || bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL result_hold: ALUOut_q=%h valid=%b want 2a/1", bus.ALUOut_q, bus.result_valid); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL result_busy: got %b want 1", bus.busy); end
    step();
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL result_stays: valid=%b want 1", bus.result_valid); end
    bus.wb_ready = 1; step(); quiet();
    n_cmp++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL result_release: valid=%b busy=%b want 0/0", bus.result_valid, bus.busy); end
  endtask

  task automatic test_branch();
    bit want [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      bus.ZERO = (i < 2); bus.Update_UC = (i == 2);
      bus.br_eq = (i == 0); bus.br_ne = (i == 1); bus.br_cmp = (i == 2);
      bus.capture = 1; bus.ALUOut = 32'(i);
      step(); quiet();
      n_cmp++; if (bus.branch_taken !== want[i] || m_br !== want[i]) begin n_bad++; $display("FAIL branch_%0d: got %b want %b", i, bus.branch_taken, want[i]); end
      bus.wb_ready = 1; step(); quiet();
      n_cmp++; if (bus.branch_taken !== 1'b0) begin n_bad++; $display("FAIL branch_clear_%0d: got %b want 0", i, bus.branch_taken); end
    end
  endtask

  task automatic test_exception();
    logic [31:0] old = m_alu;
    capture_op(32'hDEAD_BEEF, 1, 1, 32'h40);
    n_cmp++; if (bus.exc_req !== 1'b1 || bus.EPC_q !== 32'h40) begin n_bad++; $display("FAIL exc_enter: exc_req=%b EPC_q=%h want 1/40", bus.exc_req, bus.EPC_q); end
    n_cmp++; if (bus.ALUOut_q !== old || bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL exc_result: ALUOut_q=%h valid=%b want %h/0", bus.ALUOut_q, bus.result_valid, old); end
    for (int i = 0; i < 5; i++) begin
      bus.capture = 1; bus.wb_ready = 1; bus.ALUOut = 32'h777; bus.PC_in = 32'h99;
      step(); quiet();
    end
    n_cmp++; if (bus.exc_req !== 1'b1 || bus.EPC_q !== 32'h40 || bus.ALUOut_q !== old) begin n_bad++; $display("FAIL exc_hold: exc_req=%b EPC_q=%h ALUOut_q=%h", bus.exc_req, bus.EPC_q, bus.ALUOut_q); end
    bus.exc_ack = 1; step(); quiet();
    n_cmp++; if (bus.exc_req !== 1'b0 || bus.busy !== 1'b0 || bus.EPC_q !== 32'h40) begin n_bad++; $display("FAIL exc_ack: exc_req=%b busy=%b EPC_q=%h want 0/0/40", bus.exc_req, bus.busy, bus.EPC_q); end
    capture_op(32'h55, 0, 1, 32'h80);
    n_cmp++; if (bus.exc_req !== 1'b0 || bus.ALUOut_q !== 32'h55) begin n_bad++; $display("FAIL unsigned_ovf: exc_req=%b ALUOut_q=%h want 0/55", bus.exc_req, bus.ALUOut_q); end
    bus.wb_ready = 1; step(); quiet();
  endtask

  task automatic test_back_to_back();
    capture_op(32'hAAAA, 0, 0, 0);
    bus.capture = 1; bus.wb_ready = 1; bus.ALUOut = 32'h1234;
    step(); quiet();
    n_cmp++; if (bus.ALUOut_q !== 32'h1234 || bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_reload: ALUOut_q=%h valid=%b want 1234/1", bus.ALUOut_q, bus.result_valid); end
    bus.capture = 1; bus.wb_ready = 0; bus.ALUOut = 32'h5555;
    step(); quiet();
    n_cmp++; if (bus.ALUOut_q !== 32'h1234 || bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_ignore: ALUOut_q=%h valid=%b want 1234/1", bus.ALUOut_q, bus.result_valid); end
    bus.capture = 1; bus.wb_ready = 1; bus.ovf_check = 1; bus.OVERFLOW = 1; bus.PC_in = 32'h3C;
    step(); quiet();
    n_cmp++; if (bus.exc_req !== 1'b1 || bus.EPC_q !== 32'h3C || bus.ALUOut_q !== 32'h1234) begin n_bad++; $display("FAIL b2b_trap: exc_req=%b EPC_q=%h ALUOut_q=%h", bus.exc_req, bus.EPC_q, bus.ALUOut_q); end
  endtask

  task automatic test_async_reset();
    if (!m_exc) capture_op(32'h1, 1, 1, 32'h44);
    @(posedge clk); #3;
    reset = 0;
    #1;
    n_cmp++; if (bus.exc_req !== 1'b0 || bus.busy !== 1'b0 || bus.EPC_q !== 32'h0) begin n_bad++; $display("FAIL async_reset: exc_req=%b busy=%b EPC_q=%h want 0/0/0", bus.exc_req, bus.busy, bus.EPC_q); end
    model_reset();
    @(negedge clk); reset = 1;
    @(negedge clk);
  endtask

  task automatic test_exc_count();
    for (int i = 0; i < 5; i++) begin
      capture_op(32'(i), 1, 1, 32'(100 + i));
      bus.exc_ack = 1; step(); quiet();
      n_cmp++; if (bus.exc_count !== exp_cnt()) begin n_bad++; $display("FAIL exc_count_%0d: got %0d want %0d", i, bus.exc_count, exp_cnt()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.capture = ($urandom_range(1) == 1); bus.ALUOut = $urandom; bus.PC_in = $urandom;
      bus.ovf_check = ($urandom_range(1) == 1); bus.OVERFLOW = ($urandom_range(3) == 0);
      bus.ZERO = ($urandom_range(1) == 1); bus.Update_UC = ($urandom_range(1) == 1);
      bus.br_eq = ($urandom_range(2) == 0); bus.br_ne = ($urandom_range(2) == 0); bus.br_cmp = ($urandom_range(2) == 0);
      bus.wb_ready = ($urandom_range(1) == 1); bus.exc_ack = ($urandom_range(2) == 0);
      step();
      n_cmp++;
      if ({bus.ALUOut_q, bus.EPC_q, bus.result_valid, bus.branch_taken, bus.exc_req, bus.busy, bus.exc_count} !==
          {m_alu, m_epc, m_valid, m_br, m_exc, m_valid | m_exc, exp_cnt()}) begin
        n_bad++;
        $display("FAIL random_%0d: got alu=%h epc=%h v=%b br=%b exc=%b busy=%b cnt=%0d want alu=%h epc=%h v=%b br=%b exc=%b cnt=%0d",
                 i, bus.ALUOut_q, bus.EPC_q, bus.result_valid, bus.branch_taken, bus.exc_req, bus.busy, bus.exc_count,
                 m_alu, m_epc, m_valid, m_br, m_exc, exp_cnt());
      end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_result();
    test_branch();
    test_exception();
    test_back_to_back();
    test_async_reset();
    test_exc_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
